// File: rtl/hmi_pkg.sv
// hmi_pkg: shared types and constants for the HMI I/O controller.
// Holds the core I/O op encodings, the controller FSM states and the
// active-low hex-to-seven-segment table (bit 0 = segment a ... bit 6 = g).
package hmi_pkg;

  typedef enum logic [1:0] {
    IO_NONE = 2'b00,
    IO_IN   = 2'b01,
    IO_OUT  = 2'b10,
    IO_RSVD = 2'b11
  } io_op_e;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    WAIT_RELEASE = 2'b01,
    WAIT_PRESS   = 2'b10,
    DONE         = 2'b11
  } state_e;

  // Pattern that turns every segment of a digit off.
  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  // Sixteen 7-bit patterns packed with digit 0 in the least significant slot.
  localparam logic [16*7-1:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return HEX7_TABLE[nibble*7 +: 7];
  endfunction

endpackage

// File: rtl/hmi_io_controller_if.sv
// hmi_io_controller_if: request/response bundle between the core control
// unit (master) and the HMI I/O controller (slave).
interface hmi_io_controller_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_OUT_CHANNELS = 4
);
  localparam int CH_W = $clog2(NUM_OUT_CHANNELS);

  logic                  io_valid;
  logic [1:0]            io_op;
  logic [CH_W-1:0]       io_channel;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  io_done;
  logic                  stall;

  modport master (
    output io_valid, io_op, io_channel, out_data,
    input  in_data, io_done, stall
  );

  modport slave (
    input  io_valid, io_op, io_channel, out_data,
    output in_data, io_done, stall
  );
endinterface

// File: rtl/hmi_debouncer.sv
// hmi_debouncer: two-flop synchroniser plus stability counter for an
// active-low push button. The debounced level only moves after
// DEBOUNCE_CYCLES consecutive samples disagree with it, and a one-cycle
// press pulse marks each released->pressed change.
module hmi_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             sample;
  logic [CNT_W-1:0] stable_cnt;

  assign sample = ~sync_q;

  // Synchronise the raw button; reset to the released (high) level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= button_n;
      sync_q    <= sync_meta;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_cnt  <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sample == pressed) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt  <= '0;
        pressed     <= sample;
        press_pulse <= sample;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hmi_io_controller.sv
// hmi_io_controller: services core I/O requests against the board pins.
// Input ops stall the core until the operator confirms the switch value
// with a fresh debounced press; output ops latch into channel registers
// that drive the red LEDs (channel 1) and the hex display (display_sel).
// Build option: define HMI_BLANK_LEADING_ZEROS_EN to blank leading zero
// digits on the display (digit 0 always lit).
module hmi_io_controller
  import hmi_pkg::*;
#(
  parameter int IO_WIDTH         = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int FLAG_COUNT       = 5,
  parameter int DISPLAY_DIGITS   = 8,
  parameter int NUM_OUT_CHANNELS = 4,
  parameter int DEBOUNCE_CYCLES  = 50000,
  localparam int CH_W            = $clog2(NUM_OUT_CHANNELS)
) (
  input  logic                        clock,
  input  logic                        reset,
  hmi_io_controller_if.slave          bus,
  input  logic                        confirm_n,
  input  logic [IO_WIDTH-1:0]         sw,
  input  logic [CH_W-1:0]             display_sel,
  input  logic [FLAG_COUNT-1:0]       flags,
  output logic [IO_WIDTH-1:0]         rled,
  output logic [FLAG_COUNT-1:0]       gled,
  output logic [7*DISPLAY_DIGITS-1:0] sseg
);

  localparam int PAD_W    = 4 * DISPLAY_DIGITS;
  localparam int NIB_BITS = 4 * (DATA_WIDTH / 4);

  state_e                state;
  logic                  stall_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] in_data_q;
  logic [DATA_WIDTH-1:0] chan [NUM_OUT_CHANNELS];
  logic [FLAG_COUNT-1:0] gled_q;
  logic [IO_WIDTH-1:0]   sw_meta;
  logic [IO_WIDTH-1:0]   sw_sync;
  logic                  pressed;
  logic                  press_pulse;
  logic                  req_in;
  logic [CH_W:0]         wr_idx;
  logic [CH_W:0]         rd_idx;
  logic [DATA_WIDTH-1:0] disp;
  logic [PAD_W-1:0]      padded;

  hmi_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock      (clock),
    .reset      (reset),
    .button_n   (confirm_n),
    .pressed    (pressed),
    .press_pulse(press_pulse)
  );

  // Stall must rise in the request cycle itself, before the FSM registers it.
  assign req_in      = (state == IDLE) && bus.io_valid && (io_op_e'(bus.io_op) == IO_IN);
  assign bus.stall   = stall_q | req_in;
  assign bus.io_done = done_q;
  assign bus.in_data = in_data_q;
  assign gled        = gled_q;
  assign rled        = chan[1][IO_WIDTH-1:0];

  // Extra top bit lets out-of-range indices simply match no channel.
  assign wr_idx = {1'b0, bus.io_channel};
  assign rd_idx = {1'b0, display_sel};

  // Synchronise the switches so the captured value is a clean sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Request FSM: output/none/reserved ops finish in one cycle, input ops wait for the operator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
      in_data_q <= '0;
      for (int i = 0; i < NUM_OUT_CHANNELS; i++) chan[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.io_valid) begin
            case (io_op_e'(bus.io_op))
              IO_IN: begin
                stall_q <= 1'b1;
                state   <= pressed ? WAIT_RELEASE : WAIT_PRESS;
              end
              IO_OUT: begin
                for (int i = 0; i < NUM_OUT_CHANNELS; i++) begin
                  if (wr_idx == (CH_W+1)'(i)) chan[i] <= bus.out_data;
                end
                done_q <= 1'b1;
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        WAIT_RELEASE: begin
          if (!pressed) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press_pulse) begin
            in_data_q <= DATA_WIDTH'(sw_sync);
            stall_q   <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Flags are only retimed to the green LEDs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) gled_q <= '0;
    else        gled_q <= flags;
  end

  // Pick the displayed channel; unknown selections show zero.
  always_comb begin
    disp = '0;
    for (int i = 0; i < NUM_OUT_CHANNELS; i++) begin
      if (rd_idx == (CH_W+1)'(i)) disp = chan[i];
    end
  end

  // Align the value to the digit bank, zeroing digits past the data width.
  always_comb begin
    padded = '0;
    for (int i = 0; i < PAD_W; i++) begin
      if (i < NIB_BITS) padded[i] = disp[i];
    end
  end

  // Decode each nibble, scanning from the top so leading zeros can be blanked.
  always_comb begin
    logic lit;
    sseg = '1;
    lit  = 1'b0;
    for (int d = DISPLAY_DIGITS - 1; d >= 0; d--) begin
`ifdef HMI_BLANK_LEADING_ZEROS_EN
      if ((padded[4*d +: 4] != 4'h0) || (d == 0)) lit = 1'b1;
      sseg[7*d +: 7] = lit ? hex7(padded[4*d +: 4]) : SSEG_BLANK;
`else
      lit = 1'b1;
      sseg[7*d +: 7] = hex7(padded[4*d +: 4]);
`endif
    end
  end

endmodule

// File: tb/tb_hmi_io_controller.sv
// tb_hmi_io_controller: directed bench for hmi_io_controller with a small
// debounce window. Every request pushes its expected completion into a
// scoreboard; a negedge monitor pops one entry per io_done pulse.
// Build option: HMI_BLANK_LEADING_ZEROS_EN changes the expected display.
module tb_hmi_io_controller;

  localparam int IO_WIDTH         = 16;
  localparam int DATA_WIDTH       = 32;
  localparam int FLAG_COUNT       = 5;
  localparam int DISPLAY_DIGITS   = 8;
  localparam int NUM_OUT_CHANNELS = 5;
  localparam int DEBOUNCE_CYCLES  = 16;
  localparam int CH_W             = $clog2(NUM_OUT_CHANNELS);

  typedef struct {
    bit          is_input;
    logic [31:0] data;
  } sb_t;

  logic                        clock;
  logic                        reset;
  logic                        confirm_n;
  logic [IO_WIDTH-1:0]         sw;
  logic [CH_W-1:0]             display_sel;
  logic [FLAG_COUNT-1:0]       flags;
  logic [IO_WIDTH-1:0]         rled;
  logic [FLAG_COUNT-1:0]       gled;
  logic [7*DISPLAY_DIGITS-1:0] sseg;

  int  checks = 0;
  int  errors = 0;
  sb_t sb_q[$];

  hmi_io_controller_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_OUT_CHANNELS(NUM_OUT_CHANNELS)
  ) io_bus ();

  hmi_io_controller #(
    .IO_WIDTH(IO_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FLAG_COUNT(FLAG_COUNT),
    .DISPLAY_DIGITS(DISPLAY_DIGITS),
    .NUM_OUT_CHANNELS(NUM_OUT_CHANNELS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (io_bus),
    .confirm_n  (confirm_n),
    .sw         (sw),
    .display_sel(display_sel),
    .flags      (flags),
    .rled       (rled),
    .gled       (gled),
    .sseg       (sseg)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [55:0] exp_sseg(input logic [31:0] v);
    logic [55:0] r;
    logic        seen;
    r    = '1;
    seen = 1'b0;
    for (int d = 7; d >= 0; d--) begin
      if (v[4*d +: 4] != 4'h0 || d == 0) seen = 1'b1;
`ifdef HMI_BLANK_LEADING_ZEROS_EN
      r[7*d +: 7] = seen ? seg_of(v[4*d +: 4]) : 7'h7F;
`else
      r[7*d +: 7] = seg_of(v[4*d +: 4]);
`endif
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for a single cycle, starting at a negedge.
  task automatic apply_stimulus(input logic [1:0] op, input logic [CH_W-1:0] ch,
                                input logic [31:0] data, input bit expect_done,
                                input logic [31:0] exp_in, input logic exp_stall);
    io_bus.io_valid   = 1'b1;
    io_bus.io_op      = op;
    io_bus.io_channel = ch;
    io_bus.out_data   = data;
    if (expect_done) sb_q.push_back('{is_input: (op == 2'b01), data: exp_in});
    #1;
    check_output("stall_at_request", 64'(io_bus.stall), 64'(exp_stall));
    @(negedge clock);
    io_bus.io_valid = 1'b0;
    io_bus.io_op    = 2'b00;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Hold the button low, then release and let the release debounce.
  task automatic press_button(input int hold);
    confirm_n = 1'b0;
    idle_cycles(hold);
    confirm_n = 1'b1;
    idle_cycles(DEBOUNCE_CYCLES + 6);
  endtask

  // Scoreboard monitor: every io_done pulse must match a pending request.
  always @(negedge clock) begin
    if (io_bus.io_done === 1'b1) begin
      check_output("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.is_input) check_output("in_data_at_done", 64'(io_bus.in_data), 64'(e.data));
        check_output("stall_at_done", 64'(io_bus.stall), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    confirm_n = 1'b1;
    sw = '0;
    display_sel = '0;
    flags = '0;
    io_bus.io_valid = 1'b0;
    io_bus.io_op = 2'b00;
    io_bus.io_channel = '0;
    io_bus.out_data = '0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #12 reset = 1'b0;
    #1;
    check_output("reset_rled", 64'(rled), 64'd0);
    check_output("reset_gled", 64'(gled), 64'd0);
    check_output("reset_stall", 64'(io_bus.stall), 64'd0);
    check_output("reset_done", 64'(io_bus.io_done), 64'd0);
    check_output("reset_sseg", 64'(sseg), 64'({8{7'h40}}));
    check_output("reset_in_data", 64'(io_bus.in_data), 64'd0);
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(2);

    // Flags reach the green LEDs one cycle late.
    flags = 5'h15;
    #1 check_output("gled_before_edge", 64'(gled), 64'd0);
    @(negedge clock);
    check_output("gled_after_edge", 64'(gled), 64'h15);

    // Output ops and the display.
    $display("[TB] output channel writes");
    apply_stimulus(2'b10, 3'd0, 32'h0000_00F1, 1'b1, '0, 1'b0);
    check_output("sseg_ch0_F1", 64'(sseg), 64'(exp_sseg(32'h0000_00F1)));
    apply_stimulus(2'b10, 3'd1, 32'h0000_A5C3, 1'b1, '0, 1'b0);
    check_output("rled_A5C3", 64'(rled), 64'h A5C3);
    display_sel = 3'd1;
    #1 check_output("sseg_ch1_A5C3", 64'(sseg), 64'(exp_sseg(32'h0000_A5C3)));
    apply_stimulus(2'b10, 3'd2, 32'h89AB_CDEF, 1'b1, '0, 1'b0);
    display_sel = 3'd2;
    #1 check_output("sseg_ch2_full", 64'(sseg), 64'(exp_sseg(32'h89AB_CDEF)));
    apply_stimulus(2'b10, 3'd4, 32'h0000_0C0D, 1'b1, '0, 1'b0);
    display_sel = 3'd4;
    #1 check_output("sseg_last_chan", 64'(sseg), 64'(exp_sseg(32'h0000_0C0D)));

    // Out-of-range channel: completes but writes nothing.
    apply_stimulus(2'b10, 3'd7, 32'hDEAD_BEEF, 1'b1, '0, 1'b0);
    check_output("oob_rled", 64'(rled), 64'hA5C3);
    display_sel = 3'd2;
    #1 check_output("oob_ch2", 64'(sseg), 64'(exp_sseg(32'h89AB_CDEF)));
    display_sel = 3'd0;
    #1 check_output("oob_ch0", 64'(sseg), 64'(exp_sseg(32'h0000_00F1)));

    // Reserved and none ops: completion only.
    apply_stimulus(2'b11, 3'd1, 32'h0000_1111, 1'b1, '0, 1'b0);
    apply_stimulus(2'b00, 3'd1, 32'h0000_2222, 1'b1, '0, 1'b0);
    check_output("rsvd_rled", 64'(rled), 64'hA5C3);

    // Input op with a clean press.
    $display("[TB] input op, clean press");
    sw = 16'h1234;
    idle_cycles(3);
    apply_stimulus(2'b01, 3'd0, '0, 1'b1, 32'h0000_1234, 1'b1);
    idle_cycles(5);
    check_output("stall_waiting", 64'(io_bus.stall), 64'd1);
    apply_stimulus(2'b10, 3'd1, 32'h0000_FFFF, 1'b0, '0, 1'b1);
    press_button(DEBOUNCE_CYCLES + 6);
    check_output("stall_after_input", 64'(io_bus.stall), 64'd0);
    check_output("in_data_held", 64'(io_bus.in_data), 64'h1234);
    check_output("busy_write_ignored", 64'(rled), 64'hA5C3);
    check_output("sb_empty_input", 64'(sb_q.size()), 64'd0);

    // Button already held at request time must be released first.
    $display("[TB] input op, button held at request");
    confirm_n = 1'b0;
    sw = 16'hBEEF;
    idle_cycles(DEBOUNCE_CYCLES + 6);
    apply_stimulus(2'b01, 3'd0, '0, 1'b1, 32'h0000_0BAD, 1'b1);
    sw = 16'h0BAD;
    idle_cycles(30);
    check_output("held_stall", 64'(io_bus.stall), 64'd1);
    check_output("held_no_done", 64'(sb_q.size()), 64'd1);
    confirm_n = 1'b1;
    idle_cycles(DEBOUNCE_CYCLES + 6);
    check_output("released_stall", 64'(io_bus.stall), 64'd1);
    press_button(DEBOUNCE_CYCLES + 6);
    check_output("held_in_data", 64'(io_bus.in_data), 64'h0BAD);
    check_output("held_stall_low", 64'(io_bus.stall), 64'd0);

    // Bouncing button never settles, then reset aborts the wait.
    $display("[TB] bouncing button and reset abort");
    sw = 16'h5A5A;
    apply_stimulus(2'b01, 3'd0, '0, 1'b1, 32'h0000_5A5A, 1'b1);
    for (int t = 0; t < 100; t++) begin
      confirm_n = ~confirm_n;
      idle_cycles(10);
    end
    check_output("bounce_stall", 64'(io_bus.stall), 64'd1);
    check_output("bounce_no_done", 64'(sb_q.size()), 64'd1);
    check_output("bounce_in_data", 64'(io_bus.in_data), 64'h0BAD);
    #2 reset = 1'b0;
    #1;
    check_output("abort_stall", 64'(io_bus.stall), 64'd0);
    check_output("abort_done", 64'(io_bus.io_done), 64'd0);
    sb_q.delete();
    confirm_n = 1'b1;
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(40);
    check_output("abort_in_data", 64'(io_bus.in_data), 64'd0);
    check_output("abort_rled", 64'(rled), 64'd0);
    check_output("abort_sseg", 64'(sseg), 64'(exp_sseg(32'h0)));

    // Controller is back in IDLE and accepts work.
    apply_stimulus(2'b10, 3'd1, 32'h0000_0042, 1'b1, '0, 1'b0);
    check_output("recover_rled", 64'(rled), 64'h0042);
    idle_cycles(5);
    check_output("sb_empty_final", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
